frog_score_counter: RTL
=======================

Name: frog_score_counter

Overview:
- Parametrised successor to the single-digit Frogger win counter.
- Counts qualified frog arrivals (frog moves `up` while any bit of the final row is set) and shows the score on NUM_DIGITS active-low 7-segment digits.
- On reaching WIN_TARGET it runs a timed, blinking celebration, then issues a one-cycle `resetEverything` pulse and restarts from zero.
- Sits between the playfield/frog logic and the HEX displays.

Parameters:
- ROW_WIDTH, 8: width of `finalRow`.
- WIN_TARGET, 5: score that ends a round; range 1 to 10**NUM_DIGITS-1, checked at elaboration (`$error` if out of range).
- NUM_DIGITS, 2: number of BCD display digits, 1 to 4.
- CELEBRATE_CYCLES, 64: length of the celebration state in clocks, ≥ 2.
- BLINK_HALF, 8: blink half-period in clocks, ≥ 1 and < CELEBRATE_CYCLES.

Ports:
- `clk`  in  1  system clock, all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `up`  in  1  frog up-move request.
- `finalRow`  in  ROW_WIDTH  frog occupancy of the final row.
- `clear`  in  1  synchronous soft clear of the score; no `resetEverything` pulse.
- `display`  out  7*NUM_DIGITS  active-low segments; digit 0 (ones) occupies [6:0].
- `score`  out  $clog2(WIN_TARGET+1)  binary score.
- `resetEverything`  out  1  one-cycle round-restart pulse, registered.
- `celebrating`  out  1  high while in CELEBRATE.

Behaviour:
- Win detection:
  - `won_now` = `up` & (|`finalRow`).
  - Register `won_prev` <= `won_now`.
  - A qualified event is `won_now` & ~`won_prev`, i.e. a rising edge. Holding `up` counts once; this is new behaviour.
- Reset values (asynchronous):
  - state = COUNT, `score` = 0, all BCD digits = 0, `won_prev` = 1.
  - `won_prev` = 1 means an input held high through reset release does not count.
  - `resetEverything` = 0, `celebrating` = 0, timers = 0.
  - `display`: digit 0 = 7'b1000000 ("0"), all other digits = 7'b1111111 (blank).
- COUNT state:
  - A qualified event at posedge N gives `score`+1 and a BCD increment with carry across digits. The new value is visible on `score`/`display` after edge N (1-cycle latency).
  - If the incremented score equals WIN_TARGET, the next state is CELEBRATE. Load the celebration timer with CELEBRATE_CYCLES-1 and the blink timer with BLINK_HALF-1, and set the blink phase to "on".
- CELEBRATE state:
  - Qualified events are ignored; `won_prev` keeps tracking.
  - `display` alternates each BLINK_HALF clocks between the target value ("on" first) and all-blank.
  - `celebrating` = 1.
  - When the celebration timer reaches 0, go to RESTART.
- RESTART state:
  - One cycle long; `resetEverything` = 1 for exactly this cycle.
  - Score and BCD digits clear to 0.
  - Next state is COUNT.
- `clear`:
  - In COUNT, `clear` beats a simultaneous event: score becomes 0 and no increment happens.
  - In CELEBRATE, `clear` aborts to COUNT with score 0 and no `resetEverything` pulse.
  - In RESTART, `clear` has no extra effect.
- Display encoding:
  - Leading-zero suppression: digit k>0 is blank when it and all higher digits are 0.
  - Digit 0 is always shown.
- Asynchronous `reset` mid-CELEBRATE or mid-RESTART returns immediately to the reset values; no pulse is emitted.
- Wrap-around: cannot occur, because the score never exceeds WIN_TARGET.

Decomposition:
- Package `frog_pkg`:
  - enum `score_state_t` {COUNT, CELEBRATE, RESTART}.
  - 7-segment constants: `SEG_BLANK` = 7'b1111111 and digits 0–9, with 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000.
- Sub-module `seg7_decode`: combinational 4-bit BCD plus a blank flag in, 7 active-low segments out. Instantiate it NUM_DIGITS times in a generate loop.

Test Plan:
- Reset, then `up`=1 with `finalRow`=8'h80 for one cycle, then `up`=0 → `score`=1 and `display`[6:0]=7'b1111001 one cycle after the sampling edge; `display`[13:7]=7'b1111111.
- Hold `up`=1 with `finalRow`=8'h01 for 4 cycles → `score` increments once only. Also `up`=1 with `finalRow`=0 → no change.
- Five separated wins with defaults → CELEBRATE entered and `celebrating`=1. `display` blinks "5"/blank every 8 cycles for 64 cycles. Then `resetEverything`=1 for exactly 1 cycle, after which `score`=0 and `display`[6:0]=7'b1000000.
- WIN_TARGET=12, NUM_DIGITS=2 → after 10 wins `display`=digit1 "1" (7'b1111001), digit0 "0". Win 12 enters CELEBRATE.
- `clear` asserted on the same cycle as a qualified event at score 3 → `score`=0. `clear` during CELEBRATE → COUNT, score 0, no `resetEverything` pulse.
- Assert `reset` asynchronously mid-CELEBRATE (between clock edges) → outputs return to the reset values immediately, before the next edge. Hold `up`=1 through reset release → no count.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared types and 7-segment constants for the Frogger score counter.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package frog_pkg;

  typedef enum logic [1:0] {
    COUNT     = 2'd0,
    CELEBRATE = 2'd1,
    RESTART   = 2'd2
  } score_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Non-BCD codes (10..15) cannot occur in the counter; they show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/frog_score_counter_seg7_decode.sv
// One BCD digit to active-low 7-segment pattern, with a forced-blank input.
module seg7_decode
  import frog_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : bcd_to_seg(i_bcd);
  end

endmodule

// File: rtl/frog_score_counter.sv
// Frogger win counter: counts rising-edge arrivals in the final row, shows the
// score on NUM_DIGITS HEX digits and runs a blinking celebration at WIN_TARGET.
module frog_score_counter
  import frog_pkg::*;
#(
  parameter int ROW_WIDTH        = 8,
  parameter int WIN_TARGET       = 5,
  parameter int NUM_DIGITS       = 2,
  parameter int CELEBRATE_CYCLES = 64,
  parameter int BLINK_HALF       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            up,
  input  logic [ROW_WIDTH-1:0]            finalRow,
  input  logic                            clear,
  output logic [7*NUM_DIGITS-1:0]         display,
  output logic [$clog2(WIN_TARGET+1)-1:0] score,
  output logic                            resetEverything,
  output logic                            celebrating
);

  localparam int SCORE_W = $clog2(WIN_TARGET + 1);
  localparam int CEL_W   = $clog2(CELEBRATE_CYCLES);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  localparam logic [SCORE_W-1:0] TARGET     = SCORE_W'(WIN_TARGET);
  localparam logic [CEL_W-1:0]   CEL_LOAD   = CEL_W'(CELEBRATE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_digits
    $error("frog_score_counter: NUM_DIGITS must be 1..4");
  end
  if (WIN_TARGET < 1 || WIN_TARGET > 10**NUM_DIGITS - 1) begin : g_bad_target
    $error("frog_score_counter: WIN_TARGET must be 1..10**NUM_DIGITS-1");
  end
  if (CELEBRATE_CYCLES < 2) begin : g_bad_celebrate
    $error("frog_score_counter: CELEBRATE_CYCLES must be >= 2");
  end
  if (BLINK_HALF < 1 || BLINK_HALF >= CELEBRATE_CYCLES) begin : g_bad_blink
    $error("frog_score_counter: BLINK_HALF must be 1..CELEBRATE_CYCLES-1");
  end

  score_state_t        r_state;
  logic [SCORE_W-1:0]  r_score;
  logic [3:0]          r_bcd [NUM_DIGITS];
  logic                r_won_prev;
  logic [CEL_W-1:0]    r_cel_timer;
  logic [BLINK_W-1:0]  r_blink_timer;
  logic                r_blink_on;
  logic                r_reset_everything;
  logic                r_celebrating;

  logic                w_won_now;
  logic                w_event;
  logic [SCORE_W-1:0]  w_score_inc;
  logic [3:0]          w_bcd_inc [NUM_DIGITS];
  logic                w_blank_all;
  logic [NUM_DIGITS-1:0] w_blank;

  assign w_won_now   = up & (|finalRow);
  assign w_event     = w_won_now & ~r_won_prev;
  assign w_score_inc = r_score + 1'b1;

  // Decimal increment: each digit at 9 rolls to 0 and passes the carry upward.
  always_comb begin : p_bcd_inc
    logic w_carry;
    // NOTE: every comb output gets a value before any branch, so no latch can form.
    w_carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_bcd_inc[k] = r_bcd[k];
      if (w_carry) begin
        if (r_bcd[k] == 4'd9) begin
          w_bcd_inc[k] = 4'd0;
        end else begin
          w_bcd_inc[k] = r_bcd[k] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  assign w_blank_all = (r_state == CELEBRATE) && !r_blink_on;

  // Leading-zero suppression scans from the most significant digit down.
  always_comb begin : p_blank
    logic w_nonzero;
    w_nonzero = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_nonzero  = w_nonzero | (r_bcd[k] != 4'd0);
      w_blank[k] = w_blank_all | ((k != 0) & ~w_nonzero);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_decode u_seg (
      .i_bcd   (r_bcd[g]),
      .i_blank (w_blank[g]),
      .o_seg   (display[7*g +: 7])
    );
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= COUNT;
      r_score            <= '0;
      // NOTE: the digit array is a handful of flops, not a RAM, so it is reset here.
      for (int k = 0; k < NUM_DIGITS; k++) r_bcd[k] <= 4'd0;
      r_won_prev         <= 1'b1;
      r_cel_timer        <= '0;
      r_blink_timer      <= '0;
      r_blink_on         <= 1'b0;
      r_reset_everything <= 1'b0;
      r_celebrating      <= 1'b0;
    end else begin
      r_won_prev         <= w_won_now;
      r_reset_everything <= 1'b0;
      unique case (r_state)
        COUNT: begin
          if (clear) begin
            r_score <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) r_bcd[k] <= 4'd0;
          end else if (w_event) begin
            r_score <= w_score_inc;
            for (int k = 0; k < NUM_DIGITS; k++) r_bcd[k] <= w_bcd_inc[k];
            if (w_score_inc == TARGET) begin
              r_state       <= CELEBRATE;
              r_cel_timer   <= CEL_LOAD;
              r_blink_timer <= BLINK_LOAD;
              r_blink_on    <= 1'b1;
              r_celebrating <= 1'b1;
            end
          end
        end
        CELEBRATE: begin
          if (clear) begin
            r_state       <= COUNT;
            r_celebrating <= 1'b0;
            r_score       <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) r_bcd[k] <= 4'd0;
          end else if (r_cel_timer == '0) begin
            r_state            <= RESTART;
            r_celebrating      <= 1'b0;
            r_reset_everything <= 1'b1;
            r_score            <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) r_bcd[k] <= 4'd0;
          end else begin
            r_cel_timer <= r_cel_timer - 1'b1;
            if (r_blink_timer == '0) begin
              r_blink_on    <= ~r_blink_on;
              r_blink_timer <= BLINK_LOAD;
            end else begin
              r_blink_timer <= r_blink_timer - 1'b1;
            end
          end
        end
        RESTART: begin
          r_state <= COUNT;
        end
        default: begin
          r_state <= COUNT;
        end
      endcase
    end
  end

  assign score           = r_score;
  assign resetEverything = r_reset_everything;
  assign celebrating     = r_celebrating;

endmodule
